// File: rtl/unidad_pc_pkg.sv
// Shared types and constants for the fetch-side PC stage.
package unidad_pc_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int INSTR_BYTES = 4;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Next-value select for the PC register.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/unidad_pc_registro_pc.sv
// registro_pc: architectural PC register with async reset, load-enable and
// a redirect / increment / hold next-value mux. Increment wraps mod 2^XLEN.
module registro_pc
  import unidad_pc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_t         sel,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_next;
  logic            load;

  // Next-value mux; the hold leg is only a default since load gates the write.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:  pc_next = pc + XLEN'(INSTR_BYTES);
      PC_LOAD: pc_next = target;
      default: pc_next = pc;
    endcase
  end

  assign load = (sel != PC_HOLD);

  // PC storage, reloaded only when the sequencer asks for a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= pc_next;
  end

endmodule

// File: rtl/unidad_pc.sv
// unidad_pc: fetch PC stage. Issues one imem request at a time, parks the
// returned word in a single-entry slot for decode, and redirects on
// branch_taken. A redirect that lands while a request is outstanding marks
// that request killed so its response is dropped on arrival.
// Optional build macro: MISALIGN_TRAP_EN (misaligned targets trap instead of
// redirecting; adds misalign_trap / misalign_addr ports).
module unidad_pc
  import unidad_pc_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_actual
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap,
  output logic [XLEN-1:0] misalign_addr
`endif
);

  state_t          state, state_nxt;
  logic            kill, kill_nxt;
  logic [XLEN-1:0] kill_addr;
  logic [XLEN-1:0] pc;
  pc_sel_t         pc_sel;
  logic            redirect;
  logic            capture;
  logic            flush;
  logic            hide_addr;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  assign redirect   = branch_taken && !misaligned;

  // Trap pulse and offending-address capture for rejected targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_trap <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_trap <= misaligned;
      if (misaligned) misalign_addr <= branch_target;
    end
  end
`else
  assign redirect = branch_taken;
`endif

  registro_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_registro_pc (
    .clk    (clk),
    .rst    (rst),
    .sel    (pc_sel),
    .target (branch_target),
    .pc     (pc)
  );

  // Sequencer: next state, kill tracking and PC select. Redirect wins.
  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    pc_sel    = redirect ? PC_LOAD : PC_HOLD;
    capture   = 1'b0;
    flush     = 1'b0;
    hide_addr = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        if (redirect) begin
          // With an ack this edge the request is done, nothing left to kill.
          if (imem_ack) begin
            kill_nxt = 1'b0;
          end else begin
            kill_nxt  = 1'b1;
            hide_addr = !kill;
          end
        end else if (imem_ack) begin
          if (kill) begin
            kill_nxt = 1'b0;
          end else begin
            capture   = 1'b1;
            pc_sel    = PC_INC;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect || (instr_valid && instr_ready)) begin
          flush     = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and kill flag; kill_addr keeps the bus address of a killed request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      kill      <= 1'b0;
      kill_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
      if (hide_addr) kill_addr <= pc;
    end
  end

  // Instruction slot handed to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= RESET_PC;
    end else if (capture) begin
      instr_valid <= 1'b1;
      instr       <= imem_rdata;
      instr_pc    <= pc;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = kill ? kill_addr : pc;
  assign pc_actual = pc;

endmodule

// File: tb/tb_unidad_pc.sv
// Testbench for unidad_pc: directed scenarios followed by a random phase, all
// checked against a transaction-level model of the expected instruction stream.
module tb_unidad_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, instr_valid, instr_ready, branch_taken;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, branch_target, pc_actual;

  logic        req1, ack1, valid1, ready1, br1;
  logic [31:0] addr1, rdata1, instr1, ipc1, tgt1, pcact1;

`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap, trap1;
  logic [31:0] misalign_addr, maddr1;
`endif

  always #5 clk = ~clk;

  unidad_pc #(.XLEN(32), .RESET_PC(32'h0)) u0 (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .branch_taken(branch_taken), .branch_target(branch_target), .pc_actual(pc_actual)
`ifdef MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap), .misalign_addr(misalign_addr)
`endif
  );

  unidad_pc #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack1), .imem_rdata(rdata1), .instr_valid(valid1),
    .instr_ready(ready1), .instr(instr1), .instr_pc(ipc1),
    .branch_taken(br1), .branch_target(tgt1), .pc_actual(pcact1)
`ifdef MISALIGN_TRAP_EN
    , .misalign_trap(trap1), .misalign_addr(maddr1)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;
  int          cnt, dly;
  bit          rnd;
  logic [31:0] acc_q[$];
  logic [31:0] ack_q[$];
  logic [31:0] save_a, save_b;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a < 32'd16) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: pre-edge acceptance check, edge, model update, post-edge checks,
  // then drive the next cycle's inputs at the falling edge.
  task automatic tick();
    logic        pv, pr, preq, pack, eff_b;
    logic [31:0] ptgt, paddr, pinstr, ppc;
    pv = instr_valid; pr = instr_ready; preq = imem_req; pack = imem_ack;
    ptgt = branch_target; paddr = imem_addr; pinstr = instr; ppc = instr_pc;
    eff_b = branch_taken;
`ifdef MISALIGN_TRAP_EN
    if (ptgt[1:0] != 2'b00) eff_b = 1'b0;
`endif
    if (pv && pr && !eff_b) begin
      chk("acc_pc", instr_pc, exp_pc);
      chk("acc_instr", instr, memf(instr_pc));
      acc_q.push_back(instr_pc);
    end
    if (preq && pack) ack_q.push_back(paddr);
    @(posedge clk);
    #1;
    if (eff_b)         exp_pc = ptgt;
    else if (pv && pr) exp_pc = exp_pc + 32'd4;
    chk("pc_actual", pc_actual, instr_valid ? instr_pc + 32'd4 : exp_pc);
    chk("req_and_valid", {31'd0, imem_req & instr_valid}, 32'd0);
    if (preq && !pack && imem_req) chk("addr_stable", imem_addr, paddr);
    if (pv && !pr && !eff_b) begin
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", instr, pinstr);
      chk("hold_pc", instr_pc, ppc);
    end
    @(negedge clk);
    branch_taken = 1'b0;
    if (imem_req) begin
      if (cnt >= dly) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
        cnt        = 0;
        if (rnd) dly = $urandom_range(1, 4);
      end else begin
        imem_ack = 1'b0;
        cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      cnt      = 0;
    end
    if (rnd) begin
      instr_ready   = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 15) == 0);
      branch_target = 32'($urandom_range(0, 1023)) << 2;
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must drop without a clock.
  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    #1 rst = 1'b0;
    exp_pc = 32'd0; cnt = 0; imem_ack = 1'b0; branch_taken = 1'b0;
    acc_q.delete(); ack_q.delete();
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
    branch_taken = 1'b0; branch_target = '0;
    ack1 = 1'b0; rdata1 = '0; ready1 = 1'b1; br1 = 1'b0; tgt1 = '0;
    exp_pc = 32'd0; cnt = 0; dly = 1; rnd = 1'b0;
    #2;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_pc", pc_actual, 32'd0);
    chk("rst1_addr", addr1, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch, one-cycle ack latency, decode always ready.
    for (int n = 0; n < 60 && acc_q.size() < 4; n++) tick();
    chk("seq_count", acc_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("seq_ipc", (acc_q.size() > i) ? acc_q[i] : 32'hx, 32'(i * 4));
      chk("seq_addr", (ack_q.size() > i) ? ack_q[i] : 32'hx, 32'(i * 4));
    end

    // Backpressure: slot held, no fetch, restart right after ready returns.
    instr_ready = 1'b0;
    for (int n = 0; n < 20 && !instr_valid; n++) tick();
    chk("bp_valid_seen", {31'd0, instr_valid}, 32'd1);
    save_a = instr; save_b = instr_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_noreq", {31'd0, imem_req}, 32'd0);
      chk("bp_instr", instr, save_a);
      chk("bp_ipc", instr_pc, save_b);
    end
    instr_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, instr_valid}, 32'd0);
    chk("bp_release_req", {31'd0, imem_req}, 32'd1);
    chk("bp_release_addr", imem_addr, save_b + 32'd4);

    // Branch while the request for 8 is still waiting on its ack.
    rst_pulse();
    dly = 3;
    for (int n = 0; n < 60 && !(imem_req && imem_addr == 32'd8 && !imem_ack); n++) tick();
    chk("br_req8_seen", {31'd0, imem_req && imem_addr == 32'd8}, 32'd1);
    ack_q.delete(); acc_q.delete();
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk("br_addr_kept", imem_addr, 32'd8);
    chk("br_req_kept", {31'd0, imem_req}, 32'd1);
    chk("br_pc", pc_actual, 32'h40);
    for (int n = 0; n < 60 && acc_q.size() < 1; n++) tick();
    chk("br_first_ipc", (acc_q.size() > 0) ? acc_q[0] : 32'hx, 32'h40);
    chk("br_ack_old", (ack_q.size() > 0) ? ack_q[0] : 32'hx, 32'd8);
    chk("br_ack_new", (ack_q.size() > 1) ? ack_q[1] : 32'hx, 32'h40);

    // Branch in the ack cycle.
    dly = 1;
    for (int n = 0; n < 30 && !(imem_req && imem_ack); n++) tick();
    chk("ackbr_seen", {31'd0, imem_req && imem_ack}, 32'd1);
    branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    chk("ackbr_valid", {31'd0, instr_valid}, 32'd0);
    chk("ackbr_req", {31'd0, imem_req}, 32'd1);
    chk("ackbr_addr", imem_addr, 32'h100);

    // Branch in a HOLD accept cycle.
    instr_ready = 1'b0;
    for (int n = 0; n < 30 && !instr_valid; n++) tick();
    chk("accbr_valid_seen", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    chk("accbr_flush", {31'd0, instr_valid}, 32'd0);
    chk("accbr_req", {31'd0, imem_req}, 32'd1);
    chk("accbr_addr", imem_addr, 32'h100);
    for (int n = 0; n < 30 && !instr_valid; n++) tick();
    chk("accbr_ipc", instr_pc, 32'h100);

    // Async reset with a full slot, then with a pending request.
    instr_ready = 1'b0;
    for (int n = 0; n < 30 && !instr_valid; n++) tick();
    chk("rstv_seen", {31'd0, instr_valid}, 32'd1);
    rst_pulse();
    instr_ready = 1'b1;
    for (int n = 0; n < 30 && !imem_req; n++) tick();
    chk("rstq_seen", {31'd0, imem_req}, 32'd1);
    rst_pulse();

    // Wrap from 32'hFFFFFFFC on the second instance.
    tick();
    chk("wrap_req", {31'd0, req1}, 32'd1);
    chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
    ack1 = 1'b1; rdata1 = 32'h13;
    tick();
    ack1 = 1'b0;
    chk("wrap_valid", {31'd0, valid1}, 32'd1);
    chk("wrap_ipc", ipc1, 32'hFFFF_FFFC);
    chk("wrap_pc", pcact1, 32'd0);
    tick();
    chk("wrap_req2", {31'd0, req1}, 32'd1);
    chk("wrap_addr1", addr1, 32'd0);

    // Misaligned branch target while the slot is held.
    instr_ready = 1'b0;
    for (int n = 0; n < 30 && !instr_valid; n++) tick();
    save_a = pc_actual;
    branch_taken = 1'b1; branch_target = 32'h42;
    tick();
`ifdef MISALIGN_TRAP_EN
    chk("mis_pc", pc_actual, save_a);
    chk("mis_valid", {31'd0, instr_valid}, 32'd1);
    chk("mis_trap", {31'd0, misalign_trap}, 32'd1);
    chk("mis_addr", misalign_addr, 32'h42);
    tick();
    chk("mis_trap_pulse", {31'd0, misalign_trap}, 32'd0);
    instr_ready = 1'b1;
`else
    chk("mis_pc", pc_actual, 32'h42);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    acc_q.delete();
    for (int n = 0; n < 30 && acc_q.size() < 1; n++) tick();
    chk("mis_ipc", (acc_q.size() > 0) ? acc_q[0] : 32'hx, 32'h42);
`endif

    // Random traffic: ack latency, backpressure and branches.
    rnd = 1'b1;
    for (int n = 0; n < 1500; n++) tick();
    rnd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
